// File: rtl/fixed_point_pkg.sv
// Shared Q-format definitions for the fixed-point multiplier and divider.
package fixed_point_pkg;

  localparam int unsigned DEFAULT_WIDTH          = 32;
  localparam int unsigned DEFAULT_FRACTION_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_FINISH = 2'd2
  } div_state_e;

  // Saturation limits of the default Q24.8 format
  localparam logic [DEFAULT_WIDTH-1:0] Q_MAX = {1'b0, {(DEFAULT_WIDTH-1){1'b1}}};
  localparam logic [DEFAULT_WIDTH-1:0] Q_MIN = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fixed_point_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module fixed_point_div_step
  import fixed_point_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;

  always_comb begin
    shifted = {rem_in, dividend_msb};
    q_bit   = (shifted >= (WIDTH+2)'(divisor));
    rem_out = q_bit ? (WIDTH+1)'(shifted - (WIDTH+2)'(divisor)) : (WIDTH+1)'(shifted);
  end

endmodule

// File: rtl/fixed_point_divide.sv
// Sequential signed fixed-point divider: one quotient bit per cycle, saturating result.
module fixed_point_divide
  import fixed_point_pkg::*;
#(
  parameter int unsigned WIDTH          = DEFAULT_WIDTH,
  parameter int unsigned FRACTION_WIDTH = DEFAULT_FRACTION_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_ready,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_overflow,
  output logic             o_div_by_zero
);

  localparam int unsigned N     = WIDTH + FRACTION_WIDTH;
  localparam int unsigned CNT_W = $clog2(N);

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [N-1:0]     POS_LIM = {{(FRACTION_WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [N-1:0]     NEG_LIM = {{FRACTION_WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     dq;        // dividend shifts out the top, quotient shifts in the bottom
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] divisor;
  logic             sign;
  logic             a_neg;
  logic             dbz;

  logic [WIDTH-1:0] a_abs_c;
  logic [WIDTH-1:0] b_abs_c;
  logic [WIDTH:0]   rem_next_c;
  logic             q_bit_c;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;

  assign a_abs_c = i_a[WIDTH-1] ? (~i_a + WIDTH'(1)) : i_a;
  assign b_abs_c = i_b[WIDTH-1] ? (~i_b + WIDTH'(1)) : i_b;

  fixed_point_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in       (rem),
    .dividend_msb (dq[N-1]),
    .divisor      (divisor),
    .rem_out      (rem_next_c),
    .q_bit        (q_bit_c)
  );

  // Sign application and saturation of the finished quotient magnitude
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    if (dbz) begin
      res_c = a_neg ? SAT_MIN : SAT_MAX;
    end else if (!sign && (dq > POS_LIM)) begin
      res_c = SAT_MAX;
      ovf_c = 1'b1;
    end else if (sign && (dq > NEG_LIM)) begin
      res_c = SAT_MIN;
      ovf_c = 1'b1;
    end else begin
      res_c = sign ? (~dq[WIDTH-1:0] + WIDTH'(1)) : dq[WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      dq            <= '0;
      rem           <= '0;
      divisor       <= '0;
      sign          <= 1'b0;
      a_neg         <= 1'b0;
      dbz           <= 1'b0;
      o_ready       <= 1'b1;
      o_done        <= 1'b0;
      o_result      <= '0;
      o_overflow    <= 1'b0;
      o_div_by_zero <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            sign    <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            a_neg   <= i_a[WIDTH-1];
            dbz     <= (i_b == '0);
            divisor <= b_abs_c;
            dq      <= {a_abs_c, {FRACTION_WIDTH{1'b0}}};
            rem     <= '0;
            cnt     <= CNT_W'(N - 1);
            o_ready <= 1'b0;
            state   <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          rem <= rem_next_c;
          dq  <= {dq[N-2:0], q_bit_c};
          if (cnt == '0) begin
            state <= ST_FINISH;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_FINISH: begin
          o_result      <= res_c;
          o_overflow    <= ovf_c;
          o_div_by_zero <= dbz;
          o_done        <= 1'b1;
          o_ready       <= 1'b1;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
